// File: rtl/leaf_loader_pkg.sv
// Shared types and helpers for the leaf loader.
// Contents:
//   state_e       - controller states (IDLE, RUN, DRAIN, DONE)
//   TERM_WORD     - all-zero terminator word; slice it down to the data width in use
//   pipe_entry_t  - one slot of the in-flight read pipeline {valid, leaf, isTerm}
//   idxWidth      - bits needed to index N leaves
//   cntWidth      - bits needed to count 0..lenSeq+termCnt issued entries
package leaf_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The leaf field is sized for the largest supported tree; modules use only
  // the low idxWidth(LEAF_CNT) bits.
  localparam int LEAF_IDX_W = 16;
  localparam int TERM_MAX_W = 256;
  localparam logic [TERM_MAX_W-1:0] TERM_WORD = '0;

  typedef struct packed {
    logic                  valid;
    logic [LEAF_IDX_W-1:0] leaf;
    logic                  isTerm;
  } pipe_entry_t;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cntWidth(input int lenSeq, input int termCnt);
    return $clog2(lenSeq + termCnt + 1);
  endfunction

endpackage

// File: rtl/leaf_loader_rr_arbiter.sv
// Round-robin first-set search used by the leaf loader.
// Ports:
//   eligible_i    - one bit per leaf, set when that leaf may issue this cycle
//   ptr_i         - leaf index where the search starts
//   grantValid_o  - some leaf is eligible
//   grantIdx_o    - first eligible leaf at or after ptr_i, wrapping modulo N
// N must be a power of two so the index adder wraps naturally.
module leaf_rr_arbiter
  import leaf_loader_pkg::*;
#(
  parameter int N  = 256,
  parameter int IW = idxWidth(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic          grantValid_o,
  output logic [IW-1:0] grantIdx_o
);

  logic [IW-1:0] cand;

  // Walk the leaves starting at the pointer and keep the first eligible one.
  // The IW-bit candidate wraps back to leaf 0 past the top of the range.
  always_comb begin
    grantValid_o = 1'b0;
    grantIdx_o   = '0;
    cand         = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_i + IW'(k);
      if (!grantValid_o && eligible_i[cand]) begin
        grantValid_o = 1'b1;
        grantIdx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/leaf_loader.sv
// Leaf loader: fills the leaf input FIFOs of the merger tree from memory.
// Leaf i gets LEN_SEQ words from i_base + i*LEN_SEQ, then TERM_CNT zero words.
// Ports:
//   i_clk, i_rst      - clock, asynchronous active-high reset
//   i_start, i_base   - start pulse (accepted only in IDLE) and base word address
//   o_mem_rd, o_mem_addr, i_mem_data - memory read port, data MEM_LAT cycles after the read
//   i_fifo_full       - per-leaf full flags
//   o_fifo_write, o_fifo_item        - one-hot write strobe and shared write data
//   o_busy, o_done    - high in RUN; one-cycle pulse once every leaf has been written
// Optional build macro LEAF_LOADER_STATS_EN adds o_stall_cycles and o_mem_reads.
module leaf_loader
  import leaf_loader_pkg::*;
#(
  parameter int LEAF_CNT   = 256,
  parameter int LEN_SEQ    = 16,
  parameter int TERM_CNT   = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_LAT    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic [LEAF_CNT-1:0]   i_fifo_full,
  output logic [LEAF_CNT-1:0]   o_fifo_write,
  output logic [DATA_WIDTH-1:0] o_fifo_item,
  output logic                  o_busy,
  output logic                  o_done
`ifdef LEAF_LOADER_STATS_EN
  ,
  output logic [31:0]           o_stall_cycles,
  output logic [31:0]           o_mem_reads
`endif
);

  localparam int IW = idxWidth(LEAF_CNT);
  localparam int CW = cntWidth(LEN_SEQ, TERM_CNT);
  localparam logic [CW-1:0] TOTAL    = CW'(LEN_SEQ + TERM_CNT);
  localparam logic [CW-1:0] DATA_CNT = CW'(LEN_SEQ);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [IW-1:0]           ptr_q;
  logic [CW-1:0]           issued_q [LEAF_CNT];
  pipe_entry_t             pipe_q [MEM_LAT];
  logic [LEAF_CNT-1:0]     write_q;
  logic [DATA_WIDTH-1:0]   item_q;

  logic [LEAF_CNT-1:0]     inFlight;
  logic [LEAF_CNT-1:0]     eligible;
  logic                    pipeEmpty;
  logic                    allIssued;
  logic                    grantValid;
  logic [IW-1:0]           grantIdx;
  logic [CW-1:0]           grantCnt;
  logic                    issueData;
  logic                    accept;
  pipe_entry_t             pushEntry;
  pipe_entry_t             exitEntry;

  // Leaves that still have an entry anywhere in the read pipeline must not
  // issue again, so each leaf has at most one word outstanding at a time.
  always_comb begin
    inFlight  = '0;
    pipeEmpty = 1'b1;
    for (int s = 0; s < MEM_LAT; s++) begin
      if (pipe_q[s].valid) begin
        inFlight[pipe_q[s].leaf[IW-1:0]] = 1'b1;
        pipeEmpty = 1'b0;
      end
    end
  end

  // A leaf competes for the issue slot while it has entries left, its FIFO
  // reports room and it has nothing outstanding.
  always_comb begin
    allIssued = 1'b1;
    eligible  = '0;
    for (int i = 0; i < LEAF_CNT; i++) begin
      if (issued_q[i] != TOTAL) begin
        allIssued = 1'b0;
      end
      eligible[i] = (state_q == RUN) && (issued_q[i] < TOTAL)
                    && !i_fifo_full[i] && !inFlight[i];
    end
  end

  leaf_rr_arbiter #(
    .N  (LEAF_CNT),
    .IW (IW)
  ) u_arb (
    .eligible_i   (eligible),
    .ptr_i        (ptr_q),
    .grantValid_o (grantValid),
    .grantIdx_o   (grantIdx)
  );

  // The granted leaf's count decides between a memory read and a terminator.
  // Terminators still travel the pipeline so they keep order and latency.
  always_comb begin
    accept           = (state_q == IDLE) && i_start;
    grantCnt         = issued_q[grantIdx];
    issueData        = grantValid && (grantCnt < DATA_CNT);
    pushEntry.valid  = grantValid;
    pushEntry.leaf   = LEAF_IDX_W'(grantIdx);
    pushEntry.isTerm = !issueData;
    exitEntry        = pipe_q[MEM_LAT-1];
  end

  // Controller state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: run until every leaf has issued everything, then wait for the
  // pipeline to empty before signalling completion for one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start)   state_d = RUN;
      RUN:     if (allIssued) state_d = DRAIN;
      DRAIN:   if (pipeEmpty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the read address is formed combinationally from the grant so a
  // read goes out in the same cycle the leaf wins arbitration.
  always_comb begin
    o_mem_rd     = 1'b0;
    o_mem_addr   = '0;
    o_busy       = (state_q == RUN);
    o_done       = (state_q == DONE);
    o_fifo_write = write_q;
    o_fifo_item  = item_q;
    if (issueData) begin
      o_mem_rd   = 1'b1;
      o_mem_addr = base_q + ADDR_WIDTH'(grantIdx) * ADDR_WIDTH'(LEN_SEQ)
                   + ADDR_WIDTH'(grantCnt);
    end
  end

  // Datapath: base/pointer/counters, the MEM_LAT-deep tag pipeline aligned
  // with memory latency, and the registered FIFO write port at its exit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      base_q  <= '0;
      ptr_q   <= '0;
      write_q <= '0;
      item_q  <= '0;
      for (int i = 0; i < LEAF_CNT; i++) begin
        issued_q[i] <= '0;
      end
      for (int s = 0; s < MEM_LAT; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      if (accept) begin
        base_q <= i_base;
        ptr_q  <= '0;
        for (int i = 0; i < LEAF_CNT; i++) begin
          issued_q[i] <= '0;
        end
      end else if (grantValid) begin
        ptr_q              <= grantIdx + 1'b1;
        issued_q[grantIdx] <= grantCnt + 1'b1;
      end
      pipe_q[0] <= pushEntry;
      for (int s = 1; s < MEM_LAT; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
      write_q <= '0;
      if (exitEntry.valid) begin
        write_q[exitEntry.leaf[IW-1:0]] <= 1'b1;
        item_q <= exitEntry.isTerm ? TERM_WORD[DATA_WIDTH-1:0] : i_mem_data;
      end
    end
  end

`ifdef LEAF_LOADER_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] reads_q;

  // Statistics: RUN cycles where work remains but nothing could issue
  // (saturating), and the number of memory reads in the current load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_q <= '0;
      reads_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
      reads_q <= '0;
    end else begin
      if ((state_q == RUN) && !grantValid && !allIssued && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (o_mem_rd) begin
        reads_q <= reads_q + 32'd1;
      end
    end
  end

  assign o_stall_cycles = stall_q;
  assign o_mem_reads    = reads_q;
`endif

endmodule

// File: tb/tb_leaf_loader.sv
// Self-checking bench for leaf_loader in a small configuration
// (4 leaves, 5 data words + 2 terminators each, 3-cycle memory).
// The memory and the scoreboard work from the addressing and ordering rules:
// every leaf must receive its run from base+leaf*LEN_SEQ in order followed by
// zeros, data writes arrive exactly MEM_LAT+1 cycles after their read, and no
// leaf gets a write that was issued while its full flag was held.
module tb_leaf_loader;

  localparam int LC  = 4;
  localparam int LS  = 5;
  localparam int TC  = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int ML  = 3;
  localparam int TOT = LS + TC;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic          memRd;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic [LC-1:0] full;
  logic [LC-1:0] fifoWrite;
  logic [DW-1:0] fifoItem;
  logic          busy;
  logic          done;
`ifdef LEAF_LOADER_STATS_EN
  logic [31:0]   stallCycles;
  logic [31:0]   memReads;
`endif

  leaf_loader #(
    .LEAF_CNT   (LC),
    .LEN_SEQ    (LS),
    .TERM_CNT   (TC),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_LAT    (ML)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_base         (base),
    .o_mem_rd       (memRd),
    .o_mem_addr     (memAddr),
    .i_mem_data     (memData),
    .i_fifo_full    (full),
    .o_fifo_write   (fifoWrite),
    .o_fifo_item    (fifoItem),
    .o_busy         (busy),
    .o_done         (done)
`ifdef LEAF_LOADER_STATS_EN
    ,
    .o_stall_cycles (stallCycles),
    .o_mem_reads    (memReads)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            step;
    logic          expRd;
    logic [AW-1:0] expAddr;
    logic          expBusy;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic          lineRd   [ML+1];
  logic [AW-1:0] lineAddr [ML+1];

  logic [AW-1:0] mBase;
  logic [DW-1:0] mSalt;
  logic          loadActive;
  int            gotCnt [LC];
  int            readCnt [LC];
  int            lastWrite [LC];
  int            fullAge [LC];
  int            dueCyc [$];
  int            dueLeaf [$];
  int            doneCnt;
  int            totalReads;
  int            totalWrites;

  logic          sampRd;
  logic [AW-1:0] sampAddr;
  logic [LC-1:0] sampWrite;
  logic [DW-1:0] sampItem;
  logic          sampBusy;
  logic          sampDone;

  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return DW'(a) ^ mSalt;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard for one sampled cycle: reads must walk each leaf's run in
  // order, writes must carry the right word at the right time.
  task automatic scoreboard();
    logic [AW-1:0] off;
    int            leaf;
    int            n;
    logic          isData;
    logic [DW-1:0] exp;
    if (sampDone) doneCnt++;
    isData = (dueCyc.size() > 0) && (dueCyc[0] == cyc);
    if (isData) begin
      checkOutput("latency_leaf", {60'd0, sampWrite}, 64'd1 << dueLeaf[0]);
      void'(dueCyc.pop_front());
      void'(dueLeaf.pop_front());
    end
    if (sampWrite != '0) begin
      totalWrites++;
      checkOutput("write_onehot", {63'd0, $onehot(sampWrite)}, 64'd1);
      if (!loadActive) begin
        checkOutput("stale_write", {60'd0, sampWrite}, 64'd0);
      end else begin
        leaf = -1;
        for (int i = LC - 1; i >= 0; i--) if (sampWrite[i]) leaf = i;
        n = gotCnt[leaf];
        checkOutput("write_count", {63'd0, n < TOT}, 64'd1);
        if (n < TOT) begin
          exp = (n < LS) ? memWord(mBase + AW'(leaf * LS + n)) : '0;
          checkOutput($sformatf("item_leaf%0d_w%0d", leaf, n), {32'd0, sampItem}, {32'd0, exp});
          checkOutput("data_vs_term", {63'd0, isData}, {63'd0, n < LS});
        end
        if (lastWrite[leaf] >= 0) begin
          checkOutput("write_gap", {63'd0, (cyc - lastWrite[leaf]) >= ML + 1}, 64'd1);
        end
        checkOutput("write_while_full", {63'd0, fullAge[leaf] < ML + 2}, 64'd1);
        gotCnt[leaf]++;
        lastWrite[leaf] = cyc;
      end
    end
    if (sampRd) begin
      totalReads++;
      if (!loadActive) begin
        checkOutput("read_while_idle", {63'd0, sampRd}, 64'd0);
      end else begin
        off  = sampAddr - mBase;
        leaf = int'(off / AW'(LS));
        n    = int'(off % AW'(LS));
        checkOutput("read_leaf_range", {63'd0, off < AW'(LC * LS)}, 64'd1);
        if (off < AW'(LC * LS)) begin
          checkOutput("read_order", 64'(n), 64'(readCnt[leaf]));
          readCnt[leaf]++;
          dueCyc.push_back(cyc + ML + 1);
          dueLeaf.push_back(leaf);
        end
      end
    end
  endtask

  // One clock cycle: sample mid-cycle, play memory, score, then return just
  // after the next rising edge so the caller can drive the following cycle.
  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    sampRd    = memRd;
    sampAddr  = memAddr;
    sampWrite = fifoWrite;
    sampItem  = fifoItem;
    sampBusy  = busy;
    sampDone  = done;
    for (int k = ML; k > 0; k--) begin
      lineRd[k]   = lineRd[k-1];
      lineAddr[k] = lineAddr[k-1];
    end
    lineRd[0]   = memRd;
    lineAddr[0] = memAddr;
    memData = lineRd[ML] ? memWord(lineAddr[ML]) : DW'($urandom);
    for (int i = 0; i < LC; i++) fullAge[i] = full[i] ? fullAge[i] + 1 : 0;
    scoreboard();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad(input logic [AW-1:0] b, input logic [DW-1:0] s);
    mBase = b;
    mSalt = s;
    for (int i = 0; i < LC; i++) begin
      gotCnt[i] = 0;
      readCnt[i] = 0;
      lastWrite[i] = -1;
    end
    dueCyc.delete();
    dueLeaf.delete();
    doneCnt = 0;
    totalReads = 0;
    totalWrites = 0;
    loadActive = 1'b1;
    base = b;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
  endtask

  task automatic runToDone(input logic randFull);
    int n = 0;
    while (!sampDone && n < 3000) begin
      if (randFull) full = LC'($urandom) & LC'($urandom);
      else full = '0;
      applyStimulus();
      n++;
    end
    full = '0;
    checkOutput("done_seen", {63'd0, sampDone}, 64'd1);
    for (int i = 0; i < LC; i++) checkOutput($sformatf("leaf%0d_total", i), 64'(gotCnt[i]), 64'(TOT));
    checkOutput("reads_total", 64'(totalReads), 64'(LC * LS));
    checkOutput("writes_total", 64'(totalWrites), 64'(LC * TOT));
    checkOutput("pending_empty", 64'(dueCyc.size()), 64'd0);
    repeat (4) applyStimulus();
    checkOutput("done_once", 64'(doneCnt), 64'd1);
    checkOutput("busy_after_done", {63'd0, sampBusy}, 64'd0);
    loadActive = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Expected issue schedule with no full flags: step k serves leaf k%4,
    // word k/4; addresses wrap past 0xFFFFFFFF.
    vecs[0]  = '{0,  1'b1, 32'hFFFF_FFF8, 1'b1};
    vecs[1]  = '{1,  1'b1, 32'hFFFF_FFFD, 1'b1};
    vecs[2]  = '{2,  1'b1, 32'h0000_0002, 1'b1};
    vecs[3]  = '{3,  1'b1, 32'h0000_0007, 1'b1};
    vecs[4]  = '{4,  1'b1, 32'hFFFF_FFF9, 1'b1};
    vecs[5]  = '{7,  1'b1, 32'h0000_0008, 1'b1};
    vecs[6]  = '{18, 1'b1, 32'h0000_0006, 1'b1};
    vecs[7]  = '{19, 1'b1, 32'h0000_000B, 1'b1};
    vecs[8]  = '{20, 1'b0, 32'h0000_0000, 1'b1};
    vecs[9]  = '{27, 1'b0, 32'h0000_0000, 1'b1};
    vecs[10] = '{28, 1'b0, 32'h0000_0000, 1'b1};
    vecs[11] = '{29, 1'b0, 32'h0000_0000, 1'b0};

    for (int k = 0; k <= ML; k++) begin
      lineRd[k] = 1'b0;
      lineAddr[k] = '0;
    end
    for (int i = 0; i < LC; i++) begin
      gotCnt[i] = 0;
      readCnt[i] = 0;
      lastWrite[i] = -1;
      fullAge[i] = 0;
    end
    loadActive = 1'b0;
    doneCnt = 0;
    totalReads = 0;
    totalWrites = 0;
    sampDone = 1'b0;
    mBase = '0;
    mSalt = '0;
    rst = 1'b1;
    start = 1'b0;
    base = '0;
    full = '0;
    memData = '0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus();
    checkOutput("reset_mem_rd", {63'd0, sampRd}, 64'd0);
    checkOutput("reset_mem_addr", {32'd0, sampAddr}, 64'd0);
    checkOutput("reset_fifo_write", {60'd0, sampWrite}, 64'd0);
    checkOutput("reset_fifo_item", {32'd0, sampItem}, 64'd0);
    checkOutput("reset_busy", {63'd0, sampBusy}, 64'd0);
    checkOutput("reset_done", {63'd0, sampDone}, 64'd0);
    rst = 1'b0;
    applyStimulus();

    $display("[TB] table-driven issue order with wrapping base");
    begin
      int v = 0;
      startLoad(32'hFFFF_FFF8, 32'h0);
      for (int s = 0; s <= 29; s++) begin
        applyStimulus();
        if (v < NV && vecs[v].step == s) begin
          checkOutput($sformatf("vec%0d_rd", s), {63'd0, sampRd}, {63'd0, vecs[v].expRd});
          checkOutput($sformatf("vec%0d_addr", s), {32'd0, sampAddr}, {32'd0, vecs[v].expAddr});
          checkOutput($sformatf("vec%0d_busy", s), {63'd0, sampBusy}, {63'd0, vecs[v].expBusy});
          v++;
        end
      end
      checkOutput("table_applied", 64'(v), 64'(NV));
      runToDone(1'b0);
    end

    $display("[TB] leaf 3 held full for 200 cycles, start retried mid-run");
    full = 4'b1000;
    startLoad(32'h0, 32'h0);
    for (int c = 0; c < 200; c++) begin
      full = 4'b1000;
      start = (c == 50);
      base = 32'h1234_0000;
      applyStimulus();
    end
    start = 1'b0;
    checkOutput("hold_leaf3_none", 64'(gotCnt[3]), 64'd0);
    checkOutput("hold_leaf0_done", 64'(gotCnt[0]), 64'(TOT));
    checkOutput("hold_leaf2_done", 64'(gotCnt[2]), 64'(TOT));
    checkOutput("hold_busy", {63'd0, sampBusy}, 64'd1);
    runToDone(1'b0);

    $display("[TB] randomized loads against reference model");
    for (int r = 0; r < 4; r++) begin
      full = LC'($urandom);
      startLoad(AW'($urandom), DW'($urandom));
      runToDone(1'b1);
    end

    $display("[TB] reset mid-run with reads in flight");
    startLoad(32'h0000_0100, 32'hC0DE_0000);
    repeat (6) applyStimulus();
    rst = 1'b1;
    loadActive = 1'b0;
    dueCyc.delete();
    dueLeaf.delete();
    applyStimulus();
    checkOutput("abort_mem_rd", {63'd0, sampRd}, 64'd0);
    checkOutput("abort_mem_addr", {32'd0, sampAddr}, 64'd0);
    checkOutput("abort_fifo_write", {60'd0, sampWrite}, 64'd0);
    checkOutput("abort_fifo_item", {32'd0, sampItem}, 64'd0);
    checkOutput("abort_busy", {63'd0, sampBusy}, 64'd0);
    rst = 1'b0;
    for (int c = 0; c < ML + 3; c++) begin
      applyStimulus();
      checkOutput("post_reset_quiet", {60'd0, sampWrite}, 64'd0);
    end
    startLoad(32'h0000_0100, 32'h0BAD_0000);
    runToDone(1'b1);

`ifdef LEAF_LOADER_STATS_EN
    $display("[TB] statistics counters");
    full = '1;
    startLoad(32'h0000_2000, 32'h0);
    repeat (10) applyStimulus();
    checkOutput("stall_cycles", {32'd0, stallCycles}, 64'd10);
    full = '0;
    runToDone(1'b0);
    checkOutput("mem_reads", {32'd0, memReads}, 64'(LC * LS));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
